// File: rtl/bip_datapath_mc.sv
// BIP accumulator datapath: 8-op ALU, registered status flags and a
// start/busy/done handshake around a multi-cycle shift-and-add multiplier.
module bip_datapath_mc #(
    parameter int NBITS_O  = 11,
    parameter int NBITS_D  = 16,
    parameter int NBITS_OP = 3
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_Start,
    input  logic [1:0]          i_SelA,
    input  logic                i_SelB,
    input  logic                i_WrAcc,
    input  logic [NBITS_OP-1:0] i_Op,
    input  logic [NBITS_O-1:0]  i_Operand,
    input  logic [NBITS_D-1:0]  i_OutData,
    output logic [NBITS_D-1:0]  o_InData,
    output logic                o_Busy,
    output logic                o_Done,
    output logic                o_Zero,
    output logic                o_Carry,
    output logic                o_Ovf
);

    localparam int SHW = $clog2(NBITS_D);

    localparam logic [NBITS_OP-1:0] OP_ADD = NBITS_OP'(0);
    localparam logic [NBITS_OP-1:0] OP_SUB = NBITS_OP'(1);
    localparam logic [NBITS_OP-1:0] OP_AND = NBITS_OP'(2);
    localparam logic [NBITS_OP-1:0] OP_OR  = NBITS_OP'(3);
    localparam logic [NBITS_OP-1:0] OP_XOR = NBITS_OP'(4);
    localparam logic [NBITS_OP-1:0] OP_SHL = NBITS_OP'(5);
    localparam logic [NBITS_OP-1:0] OP_SRA = NBITS_OP'(6);
    localparam logic [NBITS_OP-1:0] OP_MUL = NBITS_OP'(7);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_WB} state_t;

    state_t                 state_q, state_d;
    logic [NBITS_D-1:0]     acc_q;
    logic                   zero_q, carry_q, ovf_q, done_q;
    logic [2*NBITS_D-1:0]   mcand_q, prod_q;
    logic [NBITS_D-1:0]     mplier_q;
    logic [SHW-1:0]         cnt_q;
    logic                   wr_lat_q;

    logic                   issue, mul_issue, wb, done_d;
    logic [NBITS_D-1:0]     ext, opnd_b, alu_r;
    logic                   alu_c, alu_v;
    logic [NBITS_D:0]       sum_w;
    logic [2*NBITS_D-1:0]   shl_w;
    logic signed [NBITS_D:0] sra_w;
    logic [SHW-1:0]         sh;

    assign ext    = {{(NBITS_D-NBITS_O){i_Operand[NBITS_O-1]}}, i_Operand};
    assign opnd_b = i_SelB ? ext : i_OutData;
    assign sh     = opnd_b[SHW-1:0];

    // Shifting one guard bit past the edge captures the last bit shifted out,
    // which is naturally 0 for a zero shift amount.
    assign shl_w  = {{NBITS_D{1'b0}}, acc_q} << sh;
    assign sra_w  = $signed({acc_q, 1'b0}) >>> sh;

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        sum_w = '0;
        case (i_Op)
            OP_ADD: begin
                sum_w = {1'b0, acc_q} + {1'b0, opnd_b};
                alu_r = sum_w[NBITS_D-1:0];
                alu_c = sum_w[NBITS_D];
                alu_v = (acc_q[NBITS_D-1] == opnd_b[NBITS_D-1]) &&
                        (alu_r[NBITS_D-1] != acc_q[NBITS_D-1]);
            end
            OP_SUB: begin
                sum_w = {1'b0, acc_q} + {1'b0, ~opnd_b} + {{NBITS_D{1'b0}}, 1'b1};
                alu_r = sum_w[NBITS_D-1:0];
                alu_c = sum_w[NBITS_D];
                alu_v = (acc_q[NBITS_D-1] != opnd_b[NBITS_D-1]) &&
                        (alu_r[NBITS_D-1] != acc_q[NBITS_D-1]);
            end
            OP_AND: alu_r = acc_q & opnd_b;
            OP_OR:  alu_r = acc_q | opnd_b;
            OP_XOR: alu_r = acc_q ^ opnd_b;
            OP_SHL: begin
                alu_r = shl_w[NBITS_D-1:0];
                alu_c = shl_w[NBITS_D];
            end
            OP_SRA: begin
                alu_r = sra_w[NBITS_D:1];
                alu_c = sra_w[0];
            end
            default: ;
        endcase
    end

    // NOTE: always_ff holds state with <= only; the always_comb below assigns
    // every output a default first so no latch can be inferred.
    always_ff @(posedge i_clock) begin
        if (!i_reset) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        mul_issue = 1'b0;
        wb        = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: if (i_Start) begin
                if (i_SelA == 2'b10 && i_Op == OP_MUL) begin
                    mul_issue = 1'b1;
                    state_d   = ST_MUL;
                end else begin
                    issue  = 1'b1;
                    done_d = 1'b1;
                end
            end
            ST_MUL: if (cnt_q == SHW'(NBITS_D-1)) state_d = ST_WB;
            ST_WB: begin
                wb      = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            acc_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            wr_lat_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (issue) begin
                case (i_SelA)
                    2'b00: if (i_WrAcc) acc_q <= i_OutData;
                    2'b01: if (i_WrAcc) acc_q <= ext;
                    2'b10: begin
                        if (i_WrAcc) acc_q <= alu_r;
                        zero_q  <= (alu_r == '0);
                        carry_q <= alu_c;
                        ovf_q   <= alu_v;
                    end
                    default: ;
                endcase
            end
            if (mul_issue) begin
                mcand_q  <= {{NBITS_D{1'b0}}, acc_q};
                mplier_q <= opnd_b;
                prod_q   <= '0;
                cnt_q    <= '0;
                wr_lat_q <= i_WrAcc;
            end
            if (state_q == ST_MUL) begin
                if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + SHW'(1);
            end
            if (wb) begin
                if (wr_lat_q) acc_q <= prod_q[NBITS_D-1:0];
                zero_q  <= (prod_q[NBITS_D-1:0] == '0);
                carry_q <= (prod_q[2*NBITS_D-1:NBITS_D] != '0);
                ovf_q   <= (prod_q[2*NBITS_D-1:NBITS_D] != '0);
            end
        end
    end

    assign o_InData = acc_q;
    assign o_Busy   = (state_q != ST_IDLE);
    assign o_Done   = done_q;
    assign o_Zero   = zero_q;
    assign o_Carry  = carry_q;
    assign o_Ovf    = ovf_q;

endmodule

// File: tb/tb_bip_datapath_mc.sv
// Directed bench for bip_datapath_mc: reset, loads, ALU flags, multiply timing
// with an ignored mid-run start, and reset during a multiply.
module tb_bip_datapath_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        wr_acc;
    logic [2:0]  op;
    logic [10:0] operand;
    logic [15:0] out_data;
    logic [15:0] in_data;
    logic        busy, done, zero, carry, ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bip_datapath_mc #(.NBITS_O(11), .NBITS_D(16), .NBITS_OP(3)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_Start(start), .i_SelA(sel_a),
        .i_SelB(sel_b), .i_WrAcc(wr_acc), .i_Op(op), .i_Operand(operand),
        .i_OutData(out_data), .o_InData(in_data), .o_Busy(busy), .o_Done(done),
        .o_Zero(zero), .o_Carry(carry), .o_Ovf(ovf)
    );

    // Drives one start strobe across one rising edge; returns at the falling
    // edge right after that edge, where the result is sampled.
    task automatic issue(input logic [1:0] a, input logic b, input logic w,
                         input logic [2:0] o, input logic [10:0] imm,
                         input logic [15:0] mem);
        @(negedge clk);
        start = 1'b1; sel_a = a; sel_b = b; wr_acc = w; op = o;
        operand = imm; out_data = mem;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_acc(input logic [15:0] v);
        issue(2'b00, 1'b0, 1'b1, 3'd0, 11'd0, v);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({in_data, zero, carry, ovf, busy, done} !== {16'h0, 5'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: acc=%h zcvbd=%b%b%b%b%b, want 0000 00000",
                     in_data, zero, carry, ovf, busy, done);
        end
        rst_n = 1'b1;
        issue(2'b01, 1'b0, 1'b1, 3'd0, 11'h7FF, 16'h0);
        tests_run++;
        if (in_data !== 16'hFFFF || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_ext: acc=%h done=%b, want FFFF 1", in_data, done);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || {zero, carry, ovf} !== 3'b000) begin
            tests_failed++;
            $display("FAIL load_done_pulse: done=%b zco=%b%b%b, want 0 000",
                     done, zero, carry, ovf);
        end
    endtask

    task automatic test_add_ovf;
        load_acc(16'h7FFF);
        issue(2'b10, 1'b0, 1'b1, 3'd0, 11'd0, 16'h0001);
        tests_run++;
        if ({in_data, zero, carry, ovf, done} !== {16'h8000, 4'b0011}) begin
            tests_failed++;
            $display("FAIL add_ovf: acc=%h zcvd=%b%b%b%b, want 8000 0011",
                     in_data, zero, carry, ovf, done);
        end
    endtask

    task automatic test_sub;
        load_acc(16'd5);
        issue(2'b10, 1'b1, 1'b1, 3'd1, 11'd5, 16'h0);
        tests_run++;
        if ({in_data, zero, carry, ovf} !== {16'h0000, 3'b110}) begin
            tests_failed++;
            $display("FAIL sub_zero: acc=%h zcv=%b%b%b, want 0000 110",
                     in_data, zero, carry, ovf);
        end
        load_acc(16'd5);
        issue(2'b10, 1'b1, 1'b1, 3'd1, 11'd6, 16'h0);
        tests_run++;
        if ({in_data, zero, carry, ovf} !== {16'hFFFF, 3'b000}) begin
            tests_failed++;
            $display("FAIL sub_borrow: acc=%h zcv=%b%b%b, want FFFF 000",
                     in_data, zero, carry, ovf);
        end
    endtask

    task automatic test_shift;
        load_acc(16'h8001);
        issue(2'b10, 1'b1, 1'b1, 3'd5, 11'd1, 16'h0);
        tests_run++;
        if ({in_data, zero, carry, ovf} !== {16'h0002, 3'b010}) begin
            tests_failed++;
            $display("FAIL shl_1: acc=%h zcv=%b%b%b, want 0002 010",
                     in_data, zero, carry, ovf);
        end
        load_acc(16'h8000);
        issue(2'b10, 1'b1, 1'b1, 3'd6, 11'd4, 16'h0);
        tests_run++;
        if ({in_data, zero, carry, ovf} !== {16'hF800, 3'b000}) begin
            tests_failed++;
            $display("FAIL sra_4: acc=%h zcv=%b%b%b, want F800 000",
                     in_data, zero, carry, ovf);
        end
        load_acc(16'h000F);
        issue(2'b10, 1'b0, 1'b1, 3'd6, 11'd0, 16'h0002);
        tests_run++;
        if ({in_data, zero, carry, ovf} !== {16'h0003, 3'b010}) begin
            tests_failed++;
            $display("FAIL sra_2: acc=%h zcv=%b%b%b, want 0003 010",
                     in_data, zero, carry, ovf);
        end
        issue(2'b10, 1'b1, 1'b1, 3'd5, 11'd0, 16'h0);
        tests_run++;
        if ({in_data, zero, carry, ovf} !== {16'h0003, 3'b000}) begin
            tests_failed++;
            $display("FAIL shl_0: acc=%h zcv=%b%b%b, want 0003 000",
                     in_data, zero, carry, ovf);
        end
    endtask

    task automatic test_logic;
        load_acc(16'hF0F0);
        issue(2'b10, 1'b0, 1'b1, 3'd4, 11'd0, 16'hF0F0);
        tests_run++;
        if ({in_data, zero, carry, ovf} !== {16'h0000, 3'b100}) begin
            tests_failed++;
            $display("FAIL xor_zero: acc=%h zcv=%b%b%b, want 0000 100",
                     in_data, zero, carry, ovf);
        end
        load_acc(16'h00FF);
        tests_run++;
        if (zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_keeps_flags: zero=%b, want 1", zero);
        end
        issue(2'b10, 1'b1, 1'b0, 3'd3, 11'h100, 16'h0);
        tests_run++;
        if ({in_data, zero, done} !== {16'h00FF, 2'b01}) begin
            tests_failed++;
            $display("FAIL or_nowrite: acc=%h zero=%b done=%b, want 00FF 0 1",
                     in_data, zero, done);
        end
        issue(2'b10, 1'b0, 1'b1, 3'd2, 11'd0, 16'hFF00);
        tests_run++;
        if ({in_data, zero} !== {16'h0000, 1'b1}) begin
            tests_failed++;
            $display("FAIL and_zero: acc=%h zero=%b, want 0000 1", in_data, zero);
        end
        issue(2'b11, 1'b0, 1'b1, 3'd0, 11'h123, 16'h1234);
        tests_run++;
        if ({in_data, zero, carry, ovf, done} !== {16'h0000, 4'b1001}) begin
            tests_failed++;
            $display("FAIL hold: acc=%h zcvd=%b%b%b%b, want 0000 1001",
                     in_data, zero, carry, ovf, done);
        end
    endtask

    task automatic test_mul;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = 0;
        load_acc(16'd300);
        @(negedge clk);
        issue(2'b10, 1'b0, 1'b1, 3'd7, 11'd0, 16'd300);
        // Sample k is the k-th falling edge after the issue edge.
        for (int k = 1; k <= 30; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 5) begin
                start = 1'b1; sel_a = 2'b10; op = 3'd0; out_data = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        tests_run++;
        if (busy_cnt != 17) begin
            tests_failed++;
            $display("FAIL mul_busy_cycles: got %0d, want 17", busy_cnt);
        end
        tests_run++;
        if (done_cnt != 1 || done_at != 18) begin
            tests_failed++;
            $display("FAIL mul_done: pulses=%0d at sample %0d, want 1 at 18",
                     done_cnt, done_at);
        end
        tests_run++;
        if ({in_data, zero, carry, ovf} !== {16'h5F90, 3'b011}) begin
            tests_failed++;
            $display("FAIL mul_result: acc=%h zcv=%b%b%b, want 5F90 011",
                     in_data, zero, carry, ovf);
        end
    endtask

    task automatic test_reset_mid_mul;
        int done_cnt = 0;
        load_acc(16'd7);
        issue(2'b10, 1'b1, 1'b1, 3'd7, 11'd9, 16'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({in_data, busy, done} !== {16'h0000, 2'b00}) begin
            tests_failed++;
            $display("FAIL reset_mid_mul: acc=%h busy=%b done=%b, want 0000 0 0",
                     in_data, busy, done);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        tests_run++;
        if (done_cnt != 0 || in_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_mid_mul_quiet: stray=%0d acc=%h, want 0 0000",
                     done_cnt, in_data);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sel_a = 2'b11; sel_b = 1'b0; wr_acc = 1'b0;
        op = 3'd0; operand = '0; out_data = '0;
        test_reset();
        test_add_ovf();
        test_sub();
        test_shift();
        test_logic();
        test_mul();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
